reservation_station: RTL
========================

// Module: reservation_station
// PURPOSE
//  Tomasulo reservation station for one functional unit (addSub or mulDiv instance).
//  Accepts issued instructions with operand values or producer tags, snoops the CDB for pending tags,
//  and dispatches the oldest fully-ready entry to its unit when the unit is idle.
//  Each entry owns a unique tag; the entry is released when its own tag is broadcast on the CDB.
//  Sits between the instruction bank/regStatus (issue side) and addSub/mulDiv, fed by controleCDB.
// PARAMETERS
//  ENTRIES   3  number of station entries (1..8)
//  DATA_W    4  operand/result width
//  TAG_W     4  tag width; tag 0 means "value present"
//  TAG_BASE  1  tag of entry i = TAG_BASE+i; TAG_BASE+ENTRIES-1 < 2**TAG_W, TAG_BASE != 0
// PORTS
//  clock        in   1       rising-edge clock
//  reset        in   1       asynchronous, active-high reset
//  issue_valid  in   1       issue request this cycle
//  issue_ready  out  1       comb: at least one free entry (current state)
//  issue_tag    out  TAG_W   comb: tag the next accepted issue receives (lowest free index)
//  issue_op     in   1       operation select forwarded to unit (0 add/mul, 1 sub/div)
//  issue_vj     in   DATA_W  operand A value (used when issue_qj==0)
//  issue_qj     in   TAG_W   operand A producer tag, 0 = ready
//  issue_vk     in   DATA_W  operand B value
//  issue_qk     in   TAG_W   operand B producer tag, 0 = ready
//  cdb_valid    in   1       CDB broadcast valid
//  cdb_tag      in   TAG_W   CDB tag
//  cdb_data     in   DATA_W  CDB result
//  fu_busy      in   1       unit busy (sumOcup/mulOcup)
//  disp_valid   out  1       reg: one-cycle dispatch strobe to unit
//  disp_op      out  1       reg: op of dispatched entry
//  disp_a       out  DATA_W  reg: operand A
//  disp_b       out  DATA_W  reg: operand B
//  disp_tag     out  TAG_W   reg: tag of dispatched entry
//  count        out  clog2(ENTRIES+1)  reg: occupied entries
// BEHAVIOUR
//  Reset: all entries free, disp_valid/op/a/b/tag=0, count=0; issue_ready=1, issue_tag=TAG_BASE. Mid-op reset drops all.
//  Entry state: busy, dispatched, op, Vj, Qj, Vk, Qk, age stamp; FSM per entry FREE->WAIT->DISP->FREE.
//  Issue: accepted on edge when issue_valid && issue_ready; lowest free index allocated, tag=TAG_BASE+index.
//   issue_valid while full: ignored, no state change.
//   CDB bypass: if cdb_valid && cdb_tag==issue_qj (qj!=0), store Vj=cdb_data, Qj=0; same for k.
//  Snoop: each WAIT entry with Qj==cdb_tag (both !=0, cdb_valid) captures Vj=cdb_data, Qj=0; same for k, same edge.
//  Dispatch select (comb, current regs): WAIT entries with Qj==0 && Qk==0; pick oldest (smallest issue order).
//   Allowed only if !fu_busy && !disp_valid (prevents double dispatch before busy rises).
//   On edge: disp_* loaded, disp_valid=1 for exactly one cycle, entry -> DISP. Otherwise disp_valid=0, disp_* hold.
//  Latency: issue at edge t with both operands ready -> disp_valid high in cycle after edge t+1.
//   Operand captured from CDB at edge t -> earliest disp_valid after edge t+1.
//  Release: cdb_valid && cdb_tag==entry tag && entry in DISP -> FREE on that edge; free visible next cycle.
//   Broadcast of own tag while WAIT: ignored (protocol error, no state change).
//  Simultaneous issue+release same edge: issue sees pre-edge free set; released slot reusable next cycle.
//  count = count + accepted_issue - release, updated each edge; never exceeds ENTRIES.
//  cdb_tag==0 never matches anything. Age stamp: wraps mod 2**clog2(ENTRIES)+1; order by relative age, not raw stamp.
// TESTING
//  1 Reset mid-operation with 2 busy entries -> count=0, issue_ready=1, issue_tag=1, disp_valid=0 next cycle.
//  2 Issue op0 vj=3 qj=0 vk=4 qk=0, fu_busy=0 -> disp_valid pulse 1 cycle, disp_a=3 disp_b=4 disp_tag=1.
//  3 Issue qj=5; later cdb_valid tag=5 data=7 -> Vj=7, dispatch next cycle with disp_a=7; bypass same-edge case also 7.
//  4 Fill ENTRIES=3 (tags 1,2,3), issue 4th -> ignored, issue_ready=0; CDB tag 2 after its dispatch -> next issue gets tag 2.
//  5 Two ready entries tag1 (older), tag3 (newer), fu_busy=1 then 0 -> tag1 dispatched first, tag3 only after release/idle.
//  6 Issue and CDB release on same edge while full -> issue ignored, slot freed, reissue next cycle accepted, count correct.

Source files
------------

// File: rtl/reservation_station.sv
// Tomasulo reservation station for one functional unit: holds issued instructions,
// snoops the CDB for missing operands and dispatches the oldest ready entry.
module reservation_station #(
    parameter int ENTRIES  = 3,
    parameter int DATA_W   = 4,
    parameter int TAG_W    = 4,
    parameter int TAG_BASE = 1,
    localparam int CNT_W   = $clog2(ENTRIES + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              issue_valid,
    output logic              issue_ready,
    output logic [TAG_W-1:0]  issue_tag,
    input  logic              issue_op,
    input  logic [DATA_W-1:0] issue_vj,
    input  logic [TAG_W-1:0]  issue_qj,
    input  logic [DATA_W-1:0] issue_vk,
    input  logic [TAG_W-1:0]  issue_qk,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              fu_busy,
    output logic              disp_valid,
    output logic              disp_op,
    output logic [DATA_W-1:0] disp_a,
    output logic [DATA_W-1:0] disp_b,
    output logic [TAG_W-1:0]  disp_tag,
    output logic [CNT_W-1:0]  count
);

    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    localparam logic [1:0] ST_FREE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DISP = 2'd2;

    logic [1:0]         state_r [ENTRIES];
    logic [ENTRIES-1:0] op_r;
    logic [DATA_W-1:0]  vj_r    [ENTRIES];
    logic [DATA_W-1:0]  vk_r    [ENTRIES];
    logic [TAG_W-1:0]   qj_r    [ENTRIES];
    logic [TAG_W-1:0]   qk_r    [ENTRIES];
    // older_r[i][j] set means entry j was issued before entry i
    logic [ENTRIES-1:0] older_r [ENTRIES];

    logic               disp_valid_r;
    logic               disp_op_r;
    logic [DATA_W-1:0]  disp_a_r;
    logic [DATA_W-1:0]  disp_b_r;
    logic [TAG_W-1:0]   disp_tag_r;
    logic [CNT_W-1:0]   count_r;

    logic [ENTRIES-1:0] free_vec_s;
    logic [ENTRIES-1:0] busy_vec_s;
    logic [ENTRIES-1:0] ready_vec_s;
    logic [ENTRIES-1:0] rel_vec_s;
    logic [ENTRIES-1:0] oldest_vec_s;
    logic [ENTRIES-1:0] alloc_vec_s;
    logic [ENTRIES-1:0] disp_vec_s;
    logic [IDX_W-1:0]   free_idx_s;
    logic [IDX_W-1:0]   disp_idx_s;
    logic               issue_ready_s;
    logic               issue_fire_s;
    logic               disp_fire_s;
    logic               release_s;

    function automatic logic [TAG_W-1:0] tag_of(input int idx);
        return TAG_W'(TAG_BASE + idx);
    endfunction

    function automatic logic [IDX_W-1:0] first_set(input logic [ENTRIES-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Per-entry status vectors derived from the current registers
    always_comb begin
        free_vec_s  = '0;
        busy_vec_s  = '0;
        ready_vec_s = '0;
        rel_vec_s   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            free_vec_s[i]  = (state_r[i] == ST_FREE);
            busy_vec_s[i]  = (state_r[i] != ST_FREE);
            ready_vec_s[i] = (state_r[i] == ST_WAIT) && (qj_r[i] == '0) && (qk_r[i] == '0);
            rel_vec_s[i]   = cdb_valid && (state_r[i] == ST_DISP) && (cdb_tag == tag_of(i));
        end
    end

    // Oldest-ready selection: a ready entry wins if no older entry is also ready
    always_comb begin
        oldest_vec_s = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            oldest_vec_s[i] = ready_vec_s[i] && ((ready_vec_s & older_r[i]) == '0);
        end
    end

    // Issue allocation and dispatch qualification
    always_comb begin
        issue_ready_s = |free_vec_s;
        issue_fire_s  = issue_valid && issue_ready_s;
        free_idx_s    = first_set(free_vec_s);
        disp_idx_s    = first_set(oldest_vec_s);
        disp_fire_s   = (|ready_vec_s) && !fu_busy && !disp_valid_r;
        release_s     = |rel_vec_s;
        if (issue_fire_s) begin
            alloc_vec_s = free_vec_s & (~free_vec_s + ENTRIES'(1));
        end else begin
            alloc_vec_s = '0;
        end
        if (disp_fire_s) begin
            disp_vec_s = oldest_vec_s;
        end else begin
            disp_vec_s = '0;
        end
    end

    assign issue_ready = issue_ready_s;
    assign issue_tag   = TAG_W'(TAG_BASE) + TAG_W'(free_idx_s);

    // Entry lifecycle: allocate with CDB bypass, snoop operands, dispatch, release
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_r <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                state_r[i] <= ST_FREE;
                vj_r[i]    <= '0;
                vk_r[i]    <= '0;
                qj_r[i]    <= '0;
                qk_r[i]    <= '0;
                older_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                // A newly allocated entry is younger than everyone else
                older_r[i] <= older_r[i] & ~alloc_vec_s;
                case (state_r[i])
                    ST_FREE: begin
                        if (alloc_vec_s[i]) begin
                            state_r[i] <= ST_WAIT;
                            op_r[i]    <= issue_op;
                            older_r[i] <= busy_vec_s;
                            if (cdb_valid && (issue_qj != '0) && (issue_qj == cdb_tag)) begin
                                vj_r[i] <= cdb_data;
                                qj_r[i] <= '0;
                            end else begin
                                vj_r[i] <= issue_vj;
                                qj_r[i] <= issue_qj;
                            end
                            if (cdb_valid && (issue_qk != '0) && (issue_qk == cdb_tag)) begin
                                vk_r[i] <= cdb_data;
                                qk_r[i] <= '0;
                            end else begin
                                vk_r[i] <= issue_vk;
                                qk_r[i] <= issue_qk;
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (disp_vec_s[i]) begin
                            state_r[i] <= ST_DISP;
                        end
                        if (cdb_valid && (qj_r[i] != '0) && (qj_r[i] == cdb_tag)) begin
                            vj_r[i] <= cdb_data;
                            qj_r[i] <= '0;
                        end
                        if (cdb_valid && (qk_r[i] != '0) && (qk_r[i] == cdb_tag)) begin
                            vk_r[i] <= cdb_data;
                            qk_r[i] <= '0;
                        end
                    end
                    ST_DISP: begin
                        if (rel_vec_s[i]) begin
                            state_r[i] <= ST_FREE;
                        end
                    end
                    default: begin
                        state_r[i] <= ST_FREE;
                    end
                endcase
            end
        end
    end

    // Dispatch register: one-cycle strobe, payload held between dispatches
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            disp_valid_r <= 1'b0;
            disp_op_r    <= 1'b0;
            disp_a_r     <= '0;
            disp_b_r     <= '0;
            disp_tag_r   <= '0;
        end else begin
            disp_valid_r <= disp_fire_s;
            if (disp_fire_s) begin
                disp_op_r  <= op_r[disp_idx_s];
                disp_a_r   <= vj_r[disp_idx_s];
                disp_b_r   <= vk_r[disp_idx_s];
                disp_tag_r <= TAG_W'(TAG_BASE) + TAG_W'(disp_idx_s);
            end
        end
    end

    // Occupancy counter; at most one release per edge since tags are unique
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_r <= '0;
        end else begin
            count_r <= count_r + CNT_W'(issue_fire_s) - CNT_W'(release_s);
        end
    end

    assign disp_valid = disp_valid_r;
    assign disp_op    = disp_op_r;
    assign disp_a     = disp_a_r;
    assign disp_b     = disp_b_r;
    assign disp_tag   = disp_tag_r;
    assign count      = count_r;

endmodule
